// File: rtl/aes_ctr_source.sv
// -----------------------------------------------------------------------------
// aes_ctr_source
//
// Upstream feeder for the pipelined AES-256 CTR stage. A message starts with a
// 128-bit initial counter block (IV). A stream of 32-bit plaintext words
// follows, and this block packs those words four at a time into 128-bit
// blocks. Each block is tagged with its own counter value.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   iv_valid/iv_ready   IV handshake; iv is the message's initial counter
//   s_valid/s_ready     word stream handshake; s_data word, s_last ends message
//   m_valid/m_ready     block handshake toward the AES stage
//   m_block             packed plaintext, word 0 in [127:96], unused words 0
//   m_ctr               counter block belonging to m_block
//   m_words             number of valid words in m_block (1..4)
//   m_last              m_block closes the message
//   ctr_wrap            sticky: the incrementing counter field wrapped
// -----------------------------------------------------------------------------
module aes_ctr_source #(
    parameter int CTR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         iv_valid,
    output logic         iv_ready,
    input  logic [127:0] iv,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_block,
    output logic [127:0] m_ctr,
    output logic [2:0]   m_words,
    output logic         m_last,
    output logic         ctr_wrap
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PACK  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Ones over the low CTR_WIDTH bits: the part of the counter that counts.
    function automatic logic [127:0] ctr_mask_f();
        logic [127:0] m;
        m = 128'd0;
        for (int i = 0; i < 128; i++) begin
            m[i] = (i < CTR_WIDTH);
        end
        return m;
    endfunction

    localparam logic [127:0] CTR_MASK = ctr_mask_f();

    logic [1:0]   state_r;
    logic [1:0]   idx_r;
    logic [127:0] ctr_r;
    logic [127:0] asm_r;

    logic [127:0] asm_next_s;
    logic [127:0] ctr_inc_s;
    logic         low_ones_s;
    logic         accept_s;
    logic         complete_s;
    logic         out_fire_s;

    // Handshake readiness. s_ready looks at m_ready directly, so a block
    // leaving the output register makes room for a new one in the same cycle.
    always_comb begin
        iv_ready = 1'b0;
        s_ready  = 1'b0;
        if (state_r == ST_IDLE) begin
            iv_ready = 1'b1;
        end else if (state_r == ST_PACK) begin
            s_ready = !m_valid || m_ready;
        end else begin
            iv_ready = 1'b0;
            s_ready  = 1'b0;
        end
    end

    assign accept_s   = s_valid && s_ready;
    assign complete_s = accept_s && ((idx_r == 2'd3) || s_last);
    assign out_fire_s = m_valid && m_ready;

    // Only the counting field advances; the upper bits are carried through.
    assign ctr_inc_s  = (ctr_r & ~CTR_MASK) | ((ctr_r + 128'd1) & CTR_MASK);
    assign low_ones_s = ((ctr_r & CTR_MASK) == CTR_MASK);

    // Insert the incoming word at its big-endian slot. The assembly register
    // is cleared after every block, so slots not yet written read as zero.
    always_comb begin
        asm_next_s = asm_r;
        case (idx_r)
            2'd0:    asm_next_s[127:96] = s_data;
            2'd1:    asm_next_s[95:64]  = s_data;
            2'd2:    asm_next_s[63:32]  = s_data;
            2'd3:    asm_next_s[31:0]   = s_data;
            default: asm_next_s = asm_r;
        endcase
    end

    // Message sequencing: IV load, word packing, counter advance, drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= 2'd0;
            ctr_r    <= 128'd0;
            asm_r    <= 128'd0;
            ctr_wrap <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (iv_valid) begin
                        ctr_r    <= iv;
                        idx_r    <= 2'd0;
                        asm_r    <= 128'd0;
                        ctr_wrap <= 1'b0;
                        state_r  <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (complete_s) begin
                        asm_r <= 128'd0;
                        idx_r <= 2'd0;
                        ctr_r <= ctr_inc_s;
                        if (low_ones_s) begin
                            ctr_wrap <= 1'b1;
                        end
                        if (s_last) begin
                            state_r <= ST_DRAIN;
                        end
                    end else if (accept_s) begin
                        asm_r <= asm_next_s;
                        idx_r <= idx_r + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    // Returning to IDLE only after the final block leaves
                    // keeps a single message in flight.
                    if (out_fire_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: loads on completion (even while the previous block is
    // leaving, giving no bubble), otherwise holds until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_block <= 128'd0;
            m_ctr   <= 128'd0;
            m_words <= 3'd0;
            m_last  <= 1'b0;
        end else begin
            if (complete_s) begin
                m_valid <= 1'b1;
                m_block <= asm_next_s;
                m_ctr   <= ctr_r;
                m_words <= {1'b0, idx_r} + 3'd1;
                m_last  <= s_last;
            end else if (out_fire_s) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_ctr_source.sv
// -----------------------------------------------------------------------------
// tb_aes_ctr_source
//
// Directed bench for aes_ctr_source. Expected blocks are pushed to a queue as
// words are accepted and popped when the DUT hands a block downstream.
// -----------------------------------------------------------------------------
module tb_aes_ctr_source;

    logic         clk;
    logic         rst_n;
    logic         iv_valid;
    logic         iv_ready;
    logic [127:0] iv;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_block;
    logic [127:0] m_ctr;
    logic [2:0]   m_words;
    logic         m_last;
    logic         ctr_wrap;

    aes_ctr_source #(.CTR_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iv_valid (iv_valid),
        .iv_ready (iv_ready),
        .iv       (iv),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_block  (m_block),
        .m_ctr    (m_ctr),
        .m_words  (m_words),
        .m_last   (m_last),
        .ctr_wrap (ctr_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [127:0] blk;
        logic [127:0] ctr;
        logic [2:0]   words;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] obs_blk_q[$];
    logic [127:0] obs_ctr_q[$];

    int           n_checks = 0;
    int           n_fail   = 0;

    logic [127:0] model_ctr;
    logic [127:0] model_asm;
    int           model_idx;
    logic         model_wrap;

    localparam logic [127:0] IV1 = {96'h0011_2233_4455_6677_8899_EEFF, 32'h0000_0000};
    localparam logic [127:0] IV2 = {96'h1111_2222_3333_4444_5555_6666, 32'h0000_0100};
    localparam logic [127:0] IV3 = {96'h0A0B_0C0D_0E0F_1011_1213_1415, 32'h7777_0000};
    localparam logic [127:0] IV4 = {96'hDEAD_BEEF_CAFE_F00D_1234_5678, 32'hFFFF_FFFF};
    localparam logic [127:0] IV5 = {96'h5555_5555_5555_5555_5555_5555, 32'h0000_0042};
    localparam logic [127:0] IV6 = {96'h9999_8888_7777_6666_5555_4444, 32'h0000_1000};
    localparam logic [127:0] IV7 = {96'h0123_4567_89AB_CDEF_0123_4567, 32'h0000_0010};
    localparam logic [127:0] IVX = {96'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0, 32'hBAD0_BAD0};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called once per cycle, #1 after the negedge: a block handshake will
    // happen at the coming posedge, so compare it against the scoreboard.
    task automatic observe();
        exp_t e;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_pending", 128'(sb.size()), 128'd1);
            end else begin
                e = sb.pop_front();
                chk("m_block", m_block, e.blk);
                chk("m_ctr",   m_ctr,   e.ctr);
                chk("m_words", 128'(m_words), 128'(e.words));
                chk("m_last",  128'(m_last),  128'(e.last));
                obs_blk_q.push_back(m_block);
                obs_ctr_q.push_back(m_ctr);
            end
        end
    endtask

    task automatic send_iv(input logic [127:0] v);
        bit done;
        done     = 1'b0;
        iv_valid = 1'b1;
        iv       = v;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            observe();
            if (iv_ready) begin
                done       = 1'b1;
                model_ctr  = v;
                model_idx  = 0;
                model_asm  = 128'd0;
                model_wrap = 1'b0;
            end
            @(negedge clk);
        end
        iv_valid = 1'b0;
        chk("iv_accept", 128'(done), 128'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        bit   done;
        exp_t e;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            observe();
            if (s_ready) begin
                done = 1'b1;
                model_asm[127 - 32 * model_idx -: 32] = d;
                if (model_idx == 3 || last) begin
                    e.blk   = model_asm;
                    e.ctr   = model_ctr;
                    e.words = 3'(model_idx + 1);
                    e.last  = last;
                    sb.push_back(e);
                    if (model_ctr[31:0] == 32'hFFFF_FFFF) begin
                        model_wrap = 1'b1;
                    end
                    model_ctr[31:0] = model_ctr[31:0] + 32'd1;
                    model_asm = 128'd0;
                    model_idx = 0;
                end else begin
                    model_idx++;
                end
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("word_accept", 128'(done), 128'd1);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            #1;
            observe();
            if (iv_ready && !m_valid && sb.size() == 0) begin
                done = 1'b1;
            end
            @(negedge clk);
        end
        chk("drain_idle", 128'(done), 128'd1);
        chk("iv_ready_after", 128'(iv_ready), 128'd1);
        chk("ctr_wrap", 128'(ctr_wrap), 128'(model_wrap));
    endtask

    task automatic clear_obs();
        obs_blk_q.delete();
        obs_ctr_q.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        iv_valid = 1'b0;
        iv       = 128'd0;
        s_valid  = 1'b0;
        s_data   = 32'd0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        model_ctr  = 128'd0;
        model_asm  = 128'd0;
        model_idx  = 0;
        model_wrap = 1'b0;

        // Reset state
        #1;
        chk("rst_m_valid",  128'(m_valid),  128'd0);
        chk("rst_iv_ready", 128'(iv_ready), 128'd1);
        chk("rst_s_ready",  128'(s_ready),  128'd0);
        chk("rst_m_block",  m_block, 128'd0);
        chk("rst_m_ctr",    m_ctr,   128'd0);
        chk("rst_m_words",  128'(m_words),  128'd0);
        chk("rst_ctr_wrap", 128'(ctr_wrap), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_ready = 1'b1;

        // 8-word message, free-flowing output
        clear_obs();
        send_iv(IV1);
        for (int i = 1; i <= 8; i++) send_word(32'(i), i == 8);
        wait_done();
        chk("t1_nblocks", 128'(obs_blk_q.size()), 128'd2);
        chk("t1_blk0", obs_blk_q[0], 128'h00000001_00000002_00000003_00000004);
        chk("t1_ctr0", obs_ctr_q[0], IV1);
        chk("t1_ctr1", obs_ctr_q[1], {IV1[127:32], 32'd1});

        // 6-word message: short final block
        clear_obs();
        send_iv(IV2);
        for (int i = 1; i <= 6; i++) send_word(32'(i), i == 6);
        wait_done();
        chk("t2_blk1", obs_blk_q[1], 128'h00000005_00000006_00000000_00000000);

        // Backpressure for 10 cycles after the first block
        clear_obs();
        send_iv(IV3);
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_word(32'h100 + 32'(i), 1'b0);
        s_valid = 1'b1;
        s_data  = 32'h105;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_m_valid", 128'(m_valid), 128'd1);
            chk("bp_s_ready", 128'(s_ready), 128'd0);
            chk("bp_m_block", m_block, sb[0].blk);
            chk("bp_m_ctr",   m_ctr,   sb[0].ctr);
            chk("bp_m_words", 128'(m_words), 128'(sb[0].words));
            chk("bp_m_last",  128'(m_last),  128'(sb[0].last));
            @(negedge clk);
        end
        m_ready = 1'b1;
        for (int i = 5; i <= 8; i++) send_word(32'h100 + 32'(i), i == 8);
        wait_done();
        chk("t3_nblocks", 128'(obs_blk_q.size()), 128'd2);
        chk("t3_blk1", obs_blk_q[1], 128'h00000105_00000106_00000107_00000108);

        // Counter wrap
        clear_obs();
        send_iv(IV4);
        for (int i = 1; i <= 8; i++) send_word(32'h200 + 32'(i), i == 8);
        wait_done();
        chk("t4_ctr0", obs_ctr_q[0], IV4);
        chk("t4_ctr1", obs_ctr_q[1], {IV4[127:32], 32'h0000_0000});
        chk("t4_wrap_set", 128'(ctr_wrap), 128'd1);

        // New IV clears wrap; async reset mid-message
        send_iv(IV5);
        chk("t5_wrap_clr", 128'(ctr_wrap), 128'd0);
        send_word(32'hAAAA_0001, 1'b0);
        send_word(32'hAAAA_0002, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid",  128'(m_valid),  128'd0);
        chk("arst_s_ready",  128'(s_ready),  128'd0);
        chk("arst_iv_ready", 128'(iv_ready), 128'd1);
        sb.delete();
        model_ctr  = 128'd0;
        model_asm  = 128'd0;
        model_idx  = 0;
        model_wrap = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_obs();
        send_iv(IV6);
        for (int i = 1; i <= 4; i++) send_word(32'h10 + 32'(i), i == 4);
        wait_done();
        chk("t5_nblocks", 128'(obs_blk_q.size()), 128'd1);
        chk("t5_blk0", obs_blk_q[0], 128'h00000011_00000012_00000013_00000014);
        chk("t5_ctr0", obs_ctr_q[0], IV6);

        // Stray IV offers during PACK and DRAIN are ignored
        clear_obs();
        send_iv(IV7);
        iv_valid = 1'b1;
        iv       = IVX;
        for (int i = 1; i <= 5; i++) begin
            send_word(32'h300 + 32'(i), i == 5);
            chk("pack_iv_ready", 128'(iv_ready), 128'd0);
        end
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            observe();
            chk("drain_iv_ready", 128'(iv_ready), 128'd0);
            @(negedge clk);
        end
        iv_valid = 1'b0;
        m_ready  = 1'b1;
        wait_done();
        chk("t6_nblocks", 128'(obs_ctr_q.size()), 128'd2);
        chk("t6_ctr0", obs_ctr_q[0], IV7);
        chk("t6_ctr1", obs_ctr_q[1], {IV7[127:32], 32'h0000_0011});
        chk("t6_blk1", obs_blk_q[1], 128'h00000305_00000000_00000000_00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
